// File: rtl/elevator_scheduler.sv
// Elevator request scheduler: latches floor calls and runs a LOOK sweep,
// timing floor-to-floor travel and door dwell on a single-cycle tick strobe.
module elevator_scheduler #(
    parameter int FLOORS     = 8,
    parameter int MOVE_TICKS = 4,
    parameter int DOOR_TICKS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic [FLOORS-1:0]         call_req,
    output logic [FLOORS-1:0]         destination,
    output logic [1:0]                sim_state,
    output logic [$clog2(FLOORS)-1:0] floor_idx,
    output logic                      dir_up
);

    localparam int FW   = $clog2(FLOORS);
    localparam int MAXT = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int CW   = $clog2(MAXT + 1);
    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10,
        DOOR = 2'b11
    } state_t;

    state_t            state_r, state_s;
    logic [FLOORS-1:0] pending_r, pending_s, clr_s;
    logic [FW-1:0]     floor_r, floor_s, nf_s;
    logic              dir_r, dir_s, going_up_s, above_s, below_s;
    logic [CW-1:0]     cnt_r, cnt_s;

    // Any pending call strictly above floor f.
    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++) begin
            m[i] = (FW'(i) > f);
        end
        return |(p & m);
    endfunction

    // Any pending call strictly below floor f.
    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++) begin
            m[i] = (FW'(i) < f);
        end
        return |(p & m);
    endfunction

    // Next-state, motion/dwell counter and pending-call update.
    always_comb begin
        state_s    = state_r;
        floor_s    = floor_r;
        dir_s      = dir_r;
        cnt_s      = cnt_r;
        clr_s      = '0;
        nf_s       = floor_r;
        going_up_s = (state_r == UP);
        above_s    = any_above(pending_r, floor_r);
        below_s    = any_below(pending_r, floor_r);
        if (state_r == DOOR) begin
            clr_s[floor_r] = 1'b1;
        end else begin
            clr_s = '0;
        end
        case (state_r)
            IDLE: begin
                if (tick) begin
                    cnt_s = '0;
                    if (pending_r[floor_r]) begin
                        state_s        = DOOR;
                        clr_s[floor_r] = 1'b1;
                    end else if (above_s) begin
                        state_s = UP;
                        dir_s   = 1'b1;
                    end else if (below_s) begin
                        state_s = DOWN;
                        dir_s   = 1'b0;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            UP, DOWN: begin
                if (tick) begin
                    nf_s = going_up_s ? floor_r + FW'(1) : floor_r - FW'(1);
                    if (cnt_r < MOVE_LAST) begin
                        cnt_s = cnt_r + CW'(1);
                    end else begin
                        // Arrival: decide from the calls seen relative to the new floor.
                        cnt_s   = '0;
                        floor_s = nf_s;
                        if (pending_r[nf_s]) begin
                            state_s     = DOOR;
                            clr_s[nf_s] = 1'b1;
                        end else if (going_up_s ? any_above(pending_r, nf_s)
                                                : any_below(pending_r, nf_s)) begin
                            state_s = state_r;
                        end else if (going_up_s ? any_below(pending_r, nf_s)
                                                : any_above(pending_r, nf_s)) begin
                            state_s = going_up_s ? DOWN : UP;
                            dir_s   = ~going_up_s;
                        end else begin
                            state_s = IDLE;
                        end
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            DOOR: begin
                // A call at this floor reopens the door instead of being latched.
                if (call_req[floor_r]) begin
                    cnt_s = '0;
                end else if (tick) begin
                    if (cnt_r == DOOR_LAST) begin
                        cnt_s = '0;
                        if (dir_r ? above_s : below_s) begin
                            state_s = dir_r ? UP : DOWN;
                        end else if (dir_r ? below_s : above_s) begin
                            state_s = dir_r ? DOWN : UP;
                            dir_s   = ~dir_r;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
        pending_s = (pending_r | call_req) & ~clr_s;
    end

    // State, position, direction, counter and pending-call registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            pending_r <= '0;
            floor_r   <= '0;
            dir_r     <= 1'b1;
            cnt_r     <= '0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            floor_r   <= floor_s;
            dir_r     <= dir_s;
            cnt_r     <= cnt_s;
        end
    end

    assign destination = pending_r;
    assign sim_state   = state_r;
    assign floor_idx   = floor_r;
    assign dir_up      = dir_r;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed, table-driven bench for elevator_scheduler (8 floors, 4 move ticks, 3 door ticks).
module tb_elevator_scheduler;

    logic       clk, rst, tick;
    logic [7:0] call_req, destination;
    logic [1:0] sim_state;
    logic [2:0] floor_idx;
    logic       dir_up;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] call;
        logic [7:0] dest;
        logic [1:0] st;
        logic [2:0] fl;
        logic       dir;
    } vec_t;

    vec_t tbl [17];

    elevator_scheduler #(.FLOORS(8), .MOVE_TICKS(4), .DOOR_TICKS(3)) dut (
        .clk(clk), .rst(rst), .tick(tick), .call_req(call_req),
        .destination(destination), .sim_state(sim_state),
        .floor_idx(floor_idx), .dir_up(dir_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    task automatic chk_all(input string name, input logic [7:0] dest, input logic [1:0] st,
                           input logic [2:0] fl, input logic dir);
        chk({name, " dest"}, destination, dest);
        chk({name, " state"}, {6'd0, sim_state}, {6'd0, st});
        chk({name, " floor"}, {5'd0, floor_idx}, {5'd0, fl});
        chk({name, " dir"}, {7'd0, dir_up}, {7'd0, dir});
    endtask

    task automatic step(input logic [7:0] c, input logic t);
        call_req = c;
        tick     = t;
        @(posedge clk);
        #1;
        call_req = 8'h00;
        tick     = 1'b1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(8'h00, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        call_req = 8'h00;
        tick     = 1'b1;
        rst      = 1'b1;
        #4;
        rst      = 1'b0;
        #1;
    endtask

    task automatic run_table(input int stretch);
        for (int e = 0; e < 17; e++) begin
            for (int s = 0; s < stretch; s++) begin
                step((s == 0) ? tbl[e].call : 8'h00, (s == 0));
                chk_all($sformatf("tbl x%0d e%0d s%0d", stretch, e, s),
                        tbl[e].dest, tbl[e].st, tbl[e].fl, tbl[e].dir);
            end
        end
    endtask

    initial begin
        // Single call to floor 3 from floor 0: expected outputs after each edge.
        tbl[0]  = '{8'h08, 8'h08, 2'b00, 3'd0, 1'b1};
        tbl[1]  = '{8'h00, 8'h08, 2'b01, 3'd0, 1'b1};
        tbl[2]  = '{8'h00, 8'h08, 2'b01, 3'd0, 1'b1};
        tbl[3]  = '{8'h00, 8'h08, 2'b01, 3'd0, 1'b1};
        tbl[4]  = '{8'h00, 8'h08, 2'b01, 3'd0, 1'b1};
        tbl[5]  = '{8'h00, 8'h08, 2'b01, 3'd1, 1'b1};
        tbl[6]  = '{8'h00, 8'h08, 2'b01, 3'd1, 1'b1};
        tbl[7]  = '{8'h00, 8'h08, 2'b01, 3'd1, 1'b1};
        tbl[8]  = '{8'h00, 8'h08, 2'b01, 3'd1, 1'b1};
        tbl[9]  = '{8'h00, 8'h08, 2'b01, 3'd2, 1'b1};
        tbl[10] = '{8'h00, 8'h08, 2'b01, 3'd2, 1'b1};
        tbl[11] = '{8'h00, 8'h08, 2'b01, 3'd2, 1'b1};
        tbl[12] = '{8'h00, 8'h08, 2'b01, 3'd2, 1'b1};
        tbl[13] = '{8'h00, 8'h00, 2'b11, 3'd3, 1'b1};
        tbl[14] = '{8'h00, 8'h00, 2'b11, 3'd3, 1'b1};
        tbl[15] = '{8'h00, 8'h00, 2'b11, 3'd3, 1'b1};
        tbl[16] = '{8'h00, 8'h00, 2'b00, 3'd3, 1'b1};

        rst = 1'b1; tick = 1'b1; call_req = 8'h00;
        #12;
        rst = 1'b0;
        chk_all("post reset", 8'h00, 2'b00, 3'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(8'h00, 1'b1);
            chk_all($sformatf("idle c%0d", i), 8'h00, 2'b00, 3'd0, 1'b1);
        end

        do_reset();
        run_table(1);

        // Call to 2 picked up while travelling toward 5.
        do_reset();
        step(8'h20, 1'b1);
        steps(2);
        step(8'h04, 1'b1);
        chk_all("pickup e3", 8'h24, 2'b01, 3'd0, 1'b1);
        steps(6);
        chk_all("pickup door2", 8'h20, 2'b11, 3'd2, 1'b1);
        steps(3);
        chk_all("pickup resume", 8'h20, 2'b01, 3'd2, 1'b1);
        steps(12);
        chk_all("pickup door5", 8'h00, 2'b11, 3'd5, 1'b1);
        steps(3);
        chk_all("pickup idle", 8'h00, 2'b00, 3'd5, 1'b1);

        // From floor 4, simultaneous calls 6 and 1: up first, then reverse.
        do_reset();
        step(8'h10, 1'b1);
        steps(17);
        chk_all("to4 door", 8'h00, 2'b11, 3'd4, 1'b1);
        steps(3);
        chk_all("at4 idle", 8'h00, 2'b00, 3'd4, 1'b1);
        step(8'h42, 1'b1);
        chk_all("both latched", 8'h42, 2'b00, 3'd4, 1'b1);
        step(8'h00, 1'b1);
        chk_all("up priority", 8'h42, 2'b01, 3'd4, 1'b1);
        steps(8);
        chk_all("door6", 8'h02, 2'b11, 3'd6, 1'b1);
        steps(3);
        chk_all("reverse", 8'h02, 2'b10, 3'd6, 1'b0);
        steps(20);
        chk_all("door1", 8'h00, 2'b11, 3'd1, 1'b0);
        steps(3);
        chk_all("end idle", 8'h00, 2'b00, 3'd1, 1'b0);

        // Door reopen: call at the current floor on the second dwell tick.
        do_reset();
        step(8'h08, 1'b1);
        steps(13);
        chk_all("reopen entry", 8'h00, 2'b11, 3'd3, 1'b1);
        steps(1);
        step(8'h08, 1'b1);
        chk_all("reopen pulse", 8'h00, 2'b11, 3'd3, 1'b1);
        steps(1);
        chk_all("reopen e16", 8'h00, 2'b11, 3'd3, 1'b1);
        steps(1);
        chk_all("reopen e17", 8'h00, 2'b11, 3'd3, 1'b1);
        steps(1);
        chk_all("reopen exit", 8'h00, 2'b00, 3'd3, 1'b1);

        // Asynchronous reset between edges while moving between floors 2 and 3.
        do_reset();
        step(8'h08, 1'b1);
        steps(10);
        chk_all("pre async", 8'h08, 2'b01, 3'd2, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        chk_all("async rst", 8'h00, 2'b00, 3'd0, 1'b1);
        #2;
        rst = 1'b0;
        step(8'h02, 1'b1);
        chk_all("after rst latch", 8'h02, 2'b00, 3'd0, 1'b1);
        step(8'h00, 1'b1);
        chk_all("after rst up", 8'h02, 2'b01, 3'd0, 1'b1);
        steps(4);
        chk_all("after rst door1", 8'h00, 2'b11, 3'd1, 1'b1);

        // Same single-call sequence with tick every 4th cycle.
        do_reset();
        run_table(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
